// File: rtl/seg_scan_pkg.sv
// Shared types and constants for the 7-segment scan controller.
// Segment table is indexed by hex nibble; entries are active low {dp,g,f,e,d,c,b,a}.
package seg_scan_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHOW  = 2'd1,
        BLANK = 2'd2
    } state_t;

    localparam logic [7:0] SEG_OFF = 8'hFF;

    // Entry [15] is F, entry [0] is 0.
    localparam logic [15:0][7:0] SEG_TABLE = {
        8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
        8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble + decimal point to active-low segment pattern.
module hex_to_seg7
    import seg_scan_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       dp,
    output logic [7:0] seg_n
);

    always_comb begin
        seg_n = SEG_TABLE[nibble];
        if (dp) seg_n[7] = 1'b0;
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 8-digit 7-segment scan controller with per-digit blanking gap.
// Optional build macro SEG_LEADING_ZERO_BLANK_EN blanks leading zero digits above digit 0.
//
//  state | meaning
//  IDLE  | display off, waiting for run
//  SHOW  | selected digit lit for SHOW_CYC cycles
//  BLANK | all segments off for BLANK_CYC cycles before the next digit
module seg_scan_ctrl
    import seg_scan_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 8,
    parameter int unsigned SHOW_CYC   = 50000,
    parameter int unsigned BLANK_CYC  = 1000,
    parameter int unsigned CNT_W      = 17
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic       wr_en,
    input  logic [2:0] wr_addr,
    input  logic [4:0] wr_data,
    output logic [2:0] dec_sel,
    output logic       dec_en,
    output logic [7:0] seg_n,
    output logic       frame_done
);

    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SHOW_CYC - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
    localparam logic [2:0]       LAST_IDX   = 3'(NUM_DIGITS - 1);
    localparam logic [3:0]       NUM_D      = 4'(NUM_DIGITS);
    localparam int               ND         = int'(NUM_DIGITS);

    state_t           state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [2:0]       idx, idx_d;
    logic             frame_d;
    logic             advance;
    logic             wr_ok;
    logic [4:0]       digit [8];
    logic [4:0]       view  [8];
    logic [7:0]       lz_blank;
    logic [7:0]       seg_dec;
    logic [7:0]       seg_d;

    assign wr_ok = wr_en && ({1'b0, wr_addr} < NUM_D);

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        idx_d   = idx;
        frame_d = 1'b0;
        advance = 1'b0;
        if (!run) begin
            state_d = IDLE;
            cnt_d   = '0;
            idx_d   = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_d = SHOW;
                    cnt_d   = '0;
                    idx_d   = '0;
                    advance = 1'b1;
                end
                SHOW: begin
                    if (cnt == SHOW_LAST) begin
                        state_d = BLANK;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt + CNT_W'(1);
                    end
                end
                BLANK: begin
                    if (cnt == BLANK_LAST) begin
                        state_d = SHOW;
                        cnt_d   = '0;
                        advance = 1'b1;
                        if (idx == LAST_IDX) begin
                            idx_d   = '0;
                            frame_d = 1'b1;
                        end else begin
                            idx_d = idx + 3'd1;
                        end
                    end else begin
                        cnt_d = cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            endcase
        end
    end

    // A write landing on the edge that starts a new digit is forwarded so the
    // freshly selected digit never shows stale data for a whole dwell.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            view[i] = digit[i];
            if (advance && wr_ok && (wr_addr == 3'(i))) view[i] = wr_data;
        end
    end

`ifdef SEG_LEADING_ZERO_BLANK_EN
    always_comb begin
        logic zrun;
        zrun     = 1'b1;
        lz_blank = '0;
        for (int i = ND - 1; i >= 0; i--) begin
            zrun        = zrun && (view[i] == 5'h00);
            lz_blank[i] = (i > 0) && zrun;
        end
    end
`else
    assign lz_blank = '0;
`endif

    hex_to_seg7 u_hex_to_seg7 (
        .nibble (view[idx_d][3:0]),
        .dp     (view[idx_d][4]),
        .seg_n  (seg_dec)
    );

    assign seg_d = ((state_d == SHOW) && !lz_blank[idx_d]) ? seg_dec : SEG_OFF;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            idx        <= '0;
            dec_sel    <= '0;
            dec_en     <= 1'b0;
            seg_n      <= SEG_OFF;
            frame_done <= 1'b0;
            for (int i = 0; i < 8; i++) digit[i] <= 5'h00;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            idx        <= idx_d;
            dec_sel    <= idx_d;
            dec_en     <= (state_d == SHOW);
            seg_n      <= seg_d;
            frame_done <= frame_d;
            if (wr_ok) digit[wr_addr] <= wr_data;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl (3 digits, 4 lit + 2 blank cycles) against a timeline model.
module tb_seg_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       run;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [4:0] wr_data;
    logic [2:0] dec_sel;
    logic       dec_en;
    logic [7:0] seg_n;
    logic       frame_done;

    seg_scan_ctrl #(
        .NUM_DIGITS (3),
        .SHOW_CYC   (4),
        .BLANK_CYC  (2),
        .CNT_W      (17)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .dec_sel    (dec_sel),
        .dec_en     (dec_en),
        .seg_n      (seg_n),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Model: k counts cycles since the scan started; digit period is 6, frame is 18.
    logic [4:0] mem     [3];
    logic [4:0] mem_old [3];
    bit         running;
    int         k;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    endtask

    function automatic logic [7:0] enc(input logic [4:0] v);
        logic [7:0] s;
        case (v[3:0])
            4'h0: s = 8'hC0; 4'h1: s = 8'hF9; 4'h2: s = 8'hA4; 4'h3: s = 8'hB0;
            4'h4: s = 8'h99; 4'h5: s = 8'h92; 4'h6: s = 8'h82; 4'h7: s = 8'hF8;
            4'h8: s = 8'h80; 4'h9: s = 8'h90; 4'hA: s = 8'h88; 4'hB: s = 8'h83;
            4'hC: s = 8'hC6; 4'hD: s = 8'hA1; 4'hE: s = 8'h86; default: s = 8'h8E;
        endcase
        if (v[4]) s[7] = 1'b0;
        return s;
    endfunction

    task automatic check_outputs();
        int         sel;
        logic       en, fd;
        logic [7:0] es;
        logic [4:0] src [3];
        sel = 0; en = 1'b0; fd = 1'b0; es = 8'hFF;
        if (running) begin
            sel = (k / 6) % 3;
            en  = ((k % 6) < 4);
            fd  = (k > 0) && (k % 18 == 0);
            // A digit's first lit cycle sees a same-edge write; later cycles lag one edge.
            if (k % 6 == 0) src = mem; else src = mem_old;
            if (en) begin
                es = enc(src[sel]);
`ifdef SEG_LEADING_ZERO_BLANK_EN
                begin
                    bit allz;
                    allz = 1'b1;
                    for (int j = sel; j < 3; j++) if (src[j] != 5'h00) allz = 1'b0;
                    if (sel > 0 && allz) es = 8'hFF;
                end
`endif
            end
        end
        chk("dec_sel", 32'(dec_sel), 32'(sel));
        chk("dec_en", 32'(dec_en), 32'(en));
        chk("seg_n", 32'(seg_n), 32'(es));
        chk("frame_done", 32'(frame_done), 32'(fd));
    endtask

    task automatic step(input logic r, input logic we, input logic [2:0] a, input logic [4:0] d);
        run = r; wr_en = we; wr_addr = a; wr_data = d;
        mem_old = mem;
        if (we && a < 3) mem[a] = d;
        if (!r) running = 1'b0;
        else if (!running) begin running = 1'b1; k = 0; end
        else k++;
        @(posedge clk); #1;
        check_outputs();
    endtask

    task automatic model_reset();
        running = 1'b0;
        k = 0;
        for (int i = 0; i < 3; i++) begin mem[i] = 5'h00; mem_old[i] = 5'h00; end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_sel"}, 32'(dec_sel), 32'd0);
        chk({tag, "_en"}, 32'(dec_en), 32'd0);
        chk({tag, "_seg"}, 32'(seg_n), 32'hFF);
        chk({tag, "_fd"}, 32'(frame_done), 32'd0);
    endtask

    initial begin
        model_reset();
        rst_n = 1'b0; run = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("rst_hold");
        #3 rst_n = 1'b1;

        // Free-running scan of all-zero digits over two-plus frames.
        for (int i = 0; i < 40; i++) step(1'b1, 1'b0, 3'd0, 5'd0);

        // Load 3, 7.dp, A and restart the scan.
        step(1'b0, 1'b1, 3'd0, 5'h03);
        step(1'b0, 1'b1, 3'd1, 5'h17);
        step(1'b0, 1'b1, 3'd2, 5'h0A);
        for (int i = 0; i < 24; i++) step(1'b1, 1'b0, 3'd0, 5'd0);

        // Drop run in the middle of digit 1's lit window, then resume.
        for (int i = 0; i < 40 && !(running && (k / 6) % 3 == 1 && k % 6 == 1); i++)
            step(1'b1, 1'b0, 3'd0, 5'd0);
        step(1'b0, 1'b0, 3'd0, 5'd0);
        for (int i = 0; i < 24; i++) step(1'b1, 1'b0, 3'd0, 5'd0);

        // Rewrite the lit digit, then write an out-of-range address.
        for (int i = 0; i < 40 && !(running && (k / 6) % 3 == 1 && k % 6 == 1); i++)
            step(1'b1, 1'b0, 3'd0, 5'd0);
        step(1'b1, 1'b1, 3'd1, 5'h02);
        step(1'b1, 1'b0, 3'd0, 5'd0);
        step(1'b1, 1'b1, 3'd5, 5'h1F);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 3'd0, 5'd0);

        // Asynchronous reset between edges while digit 2 is blanking.
        for (int i = 0; i < 40 && !(running && (k / 6) % 3 == 2 && k % 6 == 4); i++)
            step(1'b1, 1'b0, 3'd0, 5'd0);
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("rst_async");
        model_reset();
        #2 rst_n = 1'b1;
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 3'd0, 5'd0);

        // Randomized writes, run drops and zero-heavy data.
        for (int i = 0; i < 3000; i++) begin
            logic       r, we;
            logic [2:0] a;
            logic [4:0] d;
            r  = ($urandom_range(0, 39) != 0);
            we = ($urandom_range(0, 3) == 0);
            a  = 3'($urandom_range(0, 7));
            d  = ($urandom_range(0, 2) == 0) ? 5'h00 : 5'($urandom_range(0, 31));
            step(r, we, a, d);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
